sram_ctrl: RTL and testbench

//   Synchronous request/response front end for the 8x16 asynchronous SRAM.

---
 rtl/sram_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Request/response front end turning single-cycle requests into async SRAM pin sequences.
// Latency: write busy 2+WR_PULSE cycles; read response RD_WAIT cycles after acceptance.
// Backpressure: req_ready only in IDLE outside reset; requests seen while busy are ignored.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_ready           request handshake; req_we/req_addr/req_wdata latched on accept
//   rsp_valid/rsp_rdata           one-cycle read completion pulse, data held until next read
//   busy                          controller is in a non-IDLE state
//   sram_cs_n/we_n/oe_n/addr/io   SRAM pins, all driven from registers
module sram_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_io
);

  // The shared down-counter must hold the larger of the two wait lengths minus one.
  localparam int MAXW  = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_ACCESS
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               cs_n_q, cs_n_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               io_en_q, io_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               accept;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);

  assign sram_cs_n = cs_n_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_addr = addr_q;
  assign sram_io   = io_en_q ? wdata_q : {DATA_W{1'bz}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q counts the remaining cycles of the strobe/access window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_we) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD_ACCESS;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_STROBE;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      ST_WR_STROBE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_RD_ACCESS: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: pins are registered, so they are decoded from the state being entered.
  // IDLE and RD_ACCESS never enable the io driver, keeping oe_n low and io drive disjoint.
  always_comb begin
    cs_n_d  = 1'b1;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    io_en_d = 1'b0;
    unique case (state_d)
      ST_WR_SETUP: begin
        cs_n_d  = 1'b0;
        io_en_d = 1'b1;
      end
      ST_WR_STROBE: begin
        cs_n_d  = 1'b0;
        we_n_d  = 1'b0;
        io_en_d = 1'b1;
      end
      ST_WR_HOLD: begin
        cs_n_d  = 1'b0;
        io_en_d = 1'b1;
      end
      ST_RD_ACCESS: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase

    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end

    // Read data is captured on the edge that closes the last access cycle.
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if ((state_q == ST_RD_ACCESS) && (cnt_q == '0)) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = sram_io;
    end
  end

  // Pin and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      io_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      io_en_q     <= io_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: two instances (default timing and RD_WAIT=3/WR_PULSE=2),
// each attached to a behavioural async SRAM and checked against a reference memory.
// Stimulus and sampling happen on the falling clock edge; the monitor samples 1 unit later.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        busy      [2];
  logic        cs_n      [2];
  logic        we_n      [2];
  logic        oe_n      [2];
  logic [2:0]  sram_addr [2];
  wire  [15:0] io0;
  wire  [15:0] io1;

  sram_ctrl #(.ADDR_W(3), .DATA_W(16), .RD_WAIT(1), .WR_PULSE(1)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .sram_cs_n(cs_n[0]), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]),
    .sram_addr(sram_addr[0]), .sram_io(io0)
  );

  sram_ctrl #(.ADDR_W(3), .DATA_W(16), .RD_WAIT(3), .WR_PULSE(2)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .sram_cs_n(cs_n[1]), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]),
    .sram_addr(sram_addr[1]), .sram_io(io1)
  );

  function automatic int rw(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int wp(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  // Behavioural SRAMs: drive io while selected and output-enabled, latch on we_n fall.
  logic [15:0] mem0 [8];
  logic [15:0] mem1 [8];
  assign io0 = (!cs_n[0] && !oe_n[0] && we_n[0]) ? mem0[sram_addr[0]] : 16'bz;
  assign io1 = (!cs_n[1] && !oe_n[1] && we_n[1]) ? mem1[sram_addr[1]] : 16'bz;
  always @(negedge we_n[0]) if (!cs_n[0]) mem0[sram_addr[0]] = io0;
  always @(negedge we_n[1]) if (!cs_n[1]) mem1[sram_addr[1]] = io1;

  // Reference model: expected SRAM contents per instance.
  logic [15:0] ref_mem [2][8];
  int          rd_issued [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin-level monitor
  logic        prev_oe_n [2];
  logic        prev_we_n [2];
  logic        prev_rsp  [2];
  logic [2:0]  prev_addr [2];
  logic [15:0] prev_io   [2];
  int          we_low_total [2];
  int          rsp_seen [2];

  always begin
    @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      logic [15:0] io_v;
      logic        drv;
      io_v = (u == 0) ? io0 : io1;
      drv  = (u == 0) ? u_dut0.io_en_q : u_dut1.io_en_q;
      check_eq("bus_overlap", {31'd0, !oe_n[u] && drv}, 32'd0);
      check_eq("req_ready", {31'd0, req_ready[u]}, {31'd0, !busy[u] && !rst[u]});
      if (!busy[u])
        check_eq("idle_pins", {28'd0, cs_n[u], we_n[u], oe_n[u], drv}, 32'hE);
      if (!we_n[u])
        check_eq("turnaround", {31'd0, prev_oe_n[u]}, 32'd1);
      if (!we_n[u] && prev_we_n[u])
        check_eq("wr_setup_stable", {13'd0, sram_addr[u], io_v}, {13'd0, prev_addr[u], prev_io[u]});
      if (we_n[u] && !prev_we_n[u] && !cs_n[u])
        check_eq("wr_hold_stable", {13'd0, sram_addr[u], io_v}, {13'd0, prev_addr[u], prev_io[u]});
      if (rsp_valid[u]) begin
        rsp_seen[u]++;
        check_eq("rsp_pulse", {31'd0, prev_rsp[u]}, 32'd0);
        check_eq("rsp_unrequested", {31'd0, rsp_seen[u] <= rd_issued[u]}, 32'd1);
      end
      if (!we_n[u]) we_low_total[u]++;
      prev_oe_n[u] = oe_n[u];
      prev_we_n[u] = we_n[u];
      prev_rsp[u]  = rsp_valid[u];
      prev_addr[u] = sram_addr[u];
      prev_io[u]   = io_v;
    end
  end

  task automatic junk_req(input int u);
    req_valid[u] = 1'($urandom);
    req_we[u]    = 1'($urandom);
    req_addr[u]  = 3'($urandom);
    req_wdata[u] = 16'($urandom);
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (!req_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {31'd0, req_ready[u]}, 32'd1);
  endtask

  task automatic do_write(input int u, input logic [2:0] a, input logic [15:0] d);
    int n;
    int we0;
    wait_ready(u);
    req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = a; req_wdata[u] = d;
    @(posedge clk);
    ref_mem[u][a] = d;
    we0 = we_low_total[u];
    @(negedge clk);
    n = 0;
    while (busy[u] && n < 20) begin
      n++;
      junk_req(u);
      @(negedge clk);
    end
    req_valid[u] = 1'b0;
    check_eq("wr_busy_cycles", n, 2 + wp(u));
    check_eq("we_low_cycles", we_low_total[u] - we0, wp(u));
  endtask

  task automatic do_read(input int u, input logic [2:0] a);
    int k;
    logic [15:0] exp;
    wait_ready(u);
    req_valid[u] = 1'b1; req_we[u] = 1'b0; req_addr[u] = a; req_wdata[u] = 16'($urandom);
    @(posedge clk);
    rd_issued[u]++;
    exp = ref_mem[u][a];
    @(negedge clk);
    k = 0;
    while (!rsp_valid[u] && k < 20) begin
      junk_req(u);
      @(negedge clk);
      k++;
    end
    req_valid[u] = 1'b0;
    check_eq("rd_latency", k, rw(u));
    check_eq("rd_data", {16'd0, rsp_rdata[u]}, {16'd0, exp});
  endtask

  task automatic check_reset_pins(input int u);
    logic drv;
    drv = (u == 0) ? u_dut0.io_en_q : u_dut1.io_en_q;
    check_eq("rst_pins", {26'd0, cs_n[u], we_n[u], oe_n[u], sram_addr[u]}, 32'h38);
    check_eq("rst_io_released", {31'd0, drv}, 32'd0);
    check_eq("rst_busy_ready", {30'd0, busy[u], req_ready[u]}, 32'd0);
    check_eq("rst_rsp", {15'd0, rsp_valid[u], rsp_rdata[u]}, 32'd0);
  endtask

  // Reset a write in WR_SETUP (strobe=0) or in the first WR_STROBE cycle (strobe=1).
  task automatic rst_write(input int u, input logic [2:0] a, input logic [15:0] d, input bit strobe);
    wait_ready(u);
    req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = a; req_wdata[u] = d;
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    if (strobe) @(negedge clk);
    rst[u] = 1'b1;
    @(negedge clk);
    check_reset_pins(u);
    rst[u] = 1'b0;
    if (strobe) ref_mem[u][a] = d;
  endtask

  task automatic rst_read(input int u, input logic [2:0] a);
    wait_ready(u);
    req_valid[u] = 1'b1; req_we[u] = 1'b0; req_addr[u] = a;
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    rst[u] = 1'b1;
    @(negedge clk);
    check_reset_pins(u);
    rst[u] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0;
      req_addr[u] = '0; req_wdata[u] = '0;
      rd_issued[u] = 0; rsp_seen[u] = 0; we_low_total[u] = 0;
      prev_oe_n[u] = 1'b1; prev_we_n[u] = 1'b1; prev_rsp[u] = 1'b0;
      prev_addr[u] = '0; prev_io[u] = '0;
      for (int i = 0; i < 8; i++) ref_mem[u][i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) check_reset_pins(u);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("idle_ready", {31'd0, req_ready[u]}, 32'd1);
      check_eq("idle_no_rsp", rsp_seen[u], 0);
    end

    for (int u = 0; u < 2; u++) begin
      do_write(u, 3'd5, 16'h1234);
      do_read(u, 3'd5);
      for (int i = 0; i < 8; i++) do_write(u, 3'(i), 16'hA000 + 16'(i));
      for (int i = 0; i < 8; i++) do_read(u, 3'(i));
      rst_write(u, 3'd2, 16'hBEEF, 1'b1);
      do_read(u, 3'd2);
      rst_write(u, 3'd3, 16'h5555, 1'b0);
      do_read(u, 3'd3);
      rst_read(u, 3'd4);
      do_read(u, 3'd4);
      repeat (60) begin
        if ($urandom_range(0, 1) == 1) do_write(u, 3'($urandom), 16'($urandom));
        else                           do_read(u, 3'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) check_eq("rsp_count", rsp_seen[u], rd_issued[u]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
